// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Single-port memory controller sitting between a CPU request channel and a
// word-addressed memory with combinational read data. One request is in
// flight at a time: it is accepted in IDLE, checked, and then either rejected
// with an error pulse or played out on the memory strobes. A response pulse
// follows every accepted request.
//
// Optional feature (compile-time macro MEM_PORT_WPROT_EN):
//   When defined, non-fetch stores to the instruction region
//   (word index < INST_WORDS) are rejected with code 2'b11.
//   When undefined, such stores proceed normally and code 2'b11 never occurs.
//
// Parameters
//   WAIT_CYCLES  extra ACCESS cycles before read data is captured (0..15)
//   ADDR_WORDS   number of 32-bit words in the attached memory
//   INST_WORDS   words 0..INST_WORDS-1 form the instruction region
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   req_valid      in   CPU request present
//   req_ready      out  controller can accept a request
//   req_write      in   1 = store, 0 = load
//   req_fetch      in   instruction fetch (forces a read)
//   req_addr       in   byte address
//   req_wdata      in   store data
//   resp_valid     out  one-cycle completion pulse
//   resp_err       out  request rejected (qualified by resp_valid)
//   resp_err_code  out  01 misaligned, 10 out of range, 11 write-protect
//   ir_out         out  instruction register
//   mdr_out        out  memory data register
//   mem_addr       out  memory byte address (latched request address)
//   mem_wdata      out  memory write data (latched request data)
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   mem_rdata      in   combinational memory read data
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WORDS  = 256,
    parameter int INST_WORDS  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_fetch,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [1:0]  resp_err_code,
    output logic [31:0] ir_out,
    output logic [31:0] mdr_out,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;
    localparam logic [1:0] ST_ERR    = 2'b11;

    // Error codes reported on resp_err_code
    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_RANGE    = 2'b10;
    localparam logic [1:0] CODE_WPROT    = 2'b11;

    localparam logic [31:0] ADDR_WORDS_L = 32'(ADDR_WORDS);
    localparam logic [31:0] INST_WORDS_L = 32'(INST_WORDS);
    localparam logic [3:0]  WAIT_L       = 4'(WAIT_CYCLES);

`ifdef MEM_PORT_WPROT_EN
    localparam logic WPROT_EN = 1'b1;
`else
    localparam logic WPROT_EN = 1'b0;
`endif

    // Classify a request address; the checks are ordered so that the
    // highest-priority fault wins (misaligned, then range, then protect).
    function automatic logic [1:0] classify(
        input logic [31:0] addr,
        input logic        wprot_hit
    );
        logic [31:0] word;
        word = {2'b00, addr[31:2]};
        if (addr[1:0] != 2'b00) begin
            classify = CODE_MISALIGN;
        end else if (word >= ADDR_WORDS_L) begin
            classify = CODE_RANGE;
        end else if (wprot_hit) begin
            classify = CODE_WPROT;
        end else begin
            classify = CODE_NONE;
        end
    endfunction

    // Control state
    logic [1:0]  state_q,      state_d;
    logic        pend_q,       pend_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [1:0]  chk_code_q,   chk_code_d;

    // Latched request
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        write_q,      write_d;
    logic        fetch_q,      fetch_d;

    // Registered outputs
    logic        req_ready_q,  req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q,   resp_err_d;
    logic [1:0]  resp_code_q,  resp_code_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;
    logic [31:0] ir_q,         ir_d;
    logic [31:0] mdr_q,        mdr_d;

    // Combinational helpers
    logic        accept_s;
    logic        write_eff_s;
    logic        inst_region_s;
    logic        wprot_hit_s;
    logic        capture_s;

    assign accept_s      = req_valid & req_ready_q;
    assign write_eff_s   = req_write & ~req_fetch;
    assign inst_region_s = ({2'b00, req_addr[31:2]} < INST_WORDS_L);
    assign wprot_hit_s   = WPROT_EN & write_eff_s & inst_region_s;

    // Next-state logic: IDLE accepts and checks, ACCESS counts down the
    // wait cycles, RESP/ERR each last a single cycle.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        chk_code_d = chk_code_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        fetch_d    = fetch_q;
        capture_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    // Request was latched last edge; its classification
                    // decides between an error pulse and a memory access.
                    pend_d = 1'b0;
                    if (chk_code_q != CODE_NONE) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = WAIT_L;
                    end
                end else if (accept_s) begin
                    pend_d     = 1'b1;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    write_d    = write_eff_s;
                    fetch_d    = req_fetch;
                    chk_code_d = classify(req_addr, wprot_hit_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_RESP;
                    capture_s = ~write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, derived from the next state so every output is a
    // flop that changes on the same edge as the state it belongs to.
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE) & ~pend_d;
        resp_valid_d = (state_d == ST_RESP) | (state_d == ST_ERR);
        resp_err_d   = (state_d == ST_ERR);
        if (state_d == ST_ERR) begin
            resp_code_d = chk_code_d;
        end else begin
            resp_code_d = CODE_NONE;
        end
        // Reads strobe for the whole access; a write strobes only in the
        // final access cycle so the memory sees exactly one write edge.
        mem_read_d  = (state_d == ST_ACCESS) & ~write_d;
        mem_write_d = (state_d == ST_ACCESS) & write_d & (cnt_d == 4'd0);
        if (capture_s && fetch_q) begin
            ir_d  = mem_rdata;
            mdr_d = mdr_q;
        end else if (capture_s) begin
            ir_d  = ir_q;
            mdr_d = mem_rdata;
        end else begin
            ir_d  = ir_q;
            mdr_d = mdr_q;
        end
    end

    // Control and request-latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            cnt_q      <= 4'd0;
            chk_code_q <= CODE_NONE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            fetch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            chk_code_q <= chk_code_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            fetch_q    <= fetch_d;
        end
    end

    // Output registers; reset drops the strobes and response at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_code_q  <= CODE_NONE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ir_q         <= 32'd0;
            mdr_q        <= 32'd0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_code_q  <= resp_code_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ir_q         <= ir_d;
            mdr_q        <= mdr_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_err_code = resp_code_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign ir_out        = ir_q;
    assign mdr_out       = mdr_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_port_ctrl
//
// Directed and randomized requests against mem_port_ctrl. The bench owns a
// word memory driven by the DUT strobes and a reference model (expected
// memory image plus expected IR/MDR) that predicts codes, latencies, strobe
// counts and captured data from the request alone.
// -----------------------------------------------------------------------------
module tb_mem_port_ctrl;

    localparam int W  = 1;
    localparam int AW = 256;
    localparam int IW = 32;

`ifdef MEM_PORT_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_fetch;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [1:0]  resp_err_code;
    logic [31:0] ir_out;
    logic [31:0] mdr_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [AW];
    logic [31:0] exp_mem [AW];
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;

    int checks;
    int errors;

    mem_port_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_WORDS  (AW),
        .INST_WORDS  (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_fetch     (req_fetch),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_err      (resp_err),
        .resp_err_code (resp_err_code),
        .ir_out        (ir_out),
        .mdr_out       (mdr_out),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference classification straight from the address rules
    function automatic logic [1:0] exp_code(input logic w, input logic f, input logic [31:0] a);
        if (a % 32'd4 != 32'd0) return 2'd1;
        if (a / 32'd4 >= 32'(AW)) return 2'd2;
        if (WPROT && w && !f && (a / 32'd4 < 32'(IW))) return 2'd3;
        return 2'd0;
    endfunction

    // Issue one request and check everything observed until req_ready returns.
    // With hold set, req_valid stays high carrying the next request.
    task automatic do_req(input string tag, input logic w, input logic f,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit hold, input logic nw, input logic nf,
                          input logic [31:0] na, input logic [31:0] nd);
        logic [1:0]  code;
        logic [1:0]  seen_code;
        logic        seen_err;
        logic [31:0] wa;
        logic [31:0] wd;
        bit ok;
        bit is_wr;
        int word, n;
        int rd_cnt, wr_cnt, resp_cnt, resp_idx, ready_idx, rd_last, wr_idx;
        int both_cnt, code_bad;
        code  = exp_code(w, f, a);
        ok    = (code == 2'd0);
        is_wr = w && !f;
        word  = int'(a / 32'd4);
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; resp_idx = 0; ready_idx = 0;
        rd_last = 0; wr_idx = 0; both_cnt = 0; code_bad = 0;
        seen_err = 1'b0; seen_code = 2'd0; wa = 32'd0; wd = 32'd0;

        req_valid = 1'b1; req_write = w; req_fetch = f; req_addr = a; req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready_at_accept"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        if (hold) begin
            req_write = nw; req_fetch = nf; req_addr = na; req_wdata = nd;
        end else begin
            req_valid = 1'b0;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
        end

        for (int c = 1; c <= 40 && ready_idx == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_read === 1'b1) begin rd_cnt++; rd_last = c; end
            if (mem_write === 1'b1) begin
                wr_cnt++; wr_idx = c; wa = mem_addr; wd = mem_wdata;
                mem[mem_addr[9:2]] = mem_wdata;
            end
            if (mem_read === 1'b1 && mem_write === 1'b1) both_cnt++;
            if (resp_valid === 1'b1) begin
                resp_cnt++; resp_idx = c; seen_err = resp_err; seen_code = resp_err_code;
            end
            if (resp_err !== 1'b1 && resp_err_code !== 2'd0) code_bad++;
            if (req_ready === 1'b1) ready_idx = c;
        end

        chk({tag, "/resp_count"}, 32'(resp_cnt), 32'd1);
        chk({tag, "/resp_err"}, 32'(seen_err), ok ? 32'd0 : 32'd1);
        chk({tag, "/err_code"}, 32'(seen_code), 32'(code));
        chk({tag, "/read_cycles"}, 32'(rd_cnt), (ok && !is_wr) ? 32'(W + 1) : 32'd0);
        chk({tag, "/write_cycles"}, 32'(wr_cnt), (ok && is_wr) ? 32'd1 : 32'd0);
        chk({tag, "/strobe_overlap"}, 32'(both_cnt), 32'd0);
        chk({tag, "/code_without_err"}, 32'(code_bad), 32'd0);
        chk({tag, "/mem_addr_latched"}, mem_addr, a);
        chk({tag, "/mem_wdata_latched"}, mem_wdata, d);
        if (ok) begin
            chk({tag, "/resp_latency"}, 32'(resp_idx), 32'(W + 3));
            chk({tag, "/ready_return"}, 32'(ready_idx), 32'(W + 4));
        end else begin
            chk({tag, "/ready_after_err"}, 32'(ready_idx), 32'(resp_idx + 1));
        end
        if (ok && is_wr) begin
            chk({tag, "/write_last_access"}, 32'(wr_idx), 32'(resp_idx - 1));
            chk({tag, "/write_addr"}, wa, a);
            chk({tag, "/write_data"}, wd, d);
            exp_mem[word] = d;
        end else if (ok) begin
            chk({tag, "/read_last_access"}, 32'(rd_last), 32'(resp_idx - 1));
            if (f) exp_ir = exp_mem[word];
            else   exp_mdr = exp_mem[word];
        end else begin
            exp_ir = exp_ir;
        end
        chk({tag, "/ir_out"}, ir_out, exp_ir);
        chk({tag, "/mdr_out"}, mdr_out, exp_mdr);
    endtask

    initial begin
        int n, c, bad;
        logic [31:0] a;
        logic        w;
        logic        f;
        checks = 0; errors = 0;
        exp_ir = 32'd0; exp_mdr = 32'd0;
        for (int i = 0; i < AW; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        mem[0] = 32'h3C08_7FFF;
        exp_mem[0] = 32'h3C08_7FFF;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_fetch = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst/resp_err", 32'(resp_err), 32'd0);
        chk("rst/resp_err_code", 32'(resp_err_code), 32'd0);
        chk("rst/mem_read", 32'(mem_read), 32'd0);
        chk("rst/mem_write", 32'(mem_write), 32'd0);
        chk("rst/ir_out", ir_out, 32'd0);
        chk("rst/mdr_out", mdr_out, 32'd0);
        chk("rst/mem_addr", mem_addr, 32'd0);
        chk("rst/mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        do_req("fetch0", 1'b0, 1'b1, 32'h0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("fetch0/ir_value", ir_out, 32'h3C08_7FFF);
        do_req("store80", 1'b1, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req("load80", 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("load80/mdr_value", mdr_out, 32'hDEAD_BEEF);
        do_req("load82", 1'b0, 1'b0, 32'h82, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req("load400", 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req("store10", 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req("fetch_w10", 1'b1, 1'b1, 32'h10, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req("load3fc", 1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Back-to-back with req_valid held high
        do_req("b2b_first", 1'b0, 1'b0, 32'h84, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        do_req("b2b_second", 1'b0, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in the second access cycle of a load
        req_valid = 1'b1; req_write = 1'b0; req_fetch = 1'b0;
        req_addr = 32'h44; req_wdata = 32'h0;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        c = 0; n = 0;
        while (c < 2 && n < 20) begin
            if (mem_read === 1'b1) c++;
            if (c < 2) @(negedge clk);
            n++;
        end
        chk("rstmid/reached_second_access", 32'(c), 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("rstmid/mem_read", 32'(mem_read), 32'd0);
        chk("rstmid/mem_write", 32'(mem_write), 32'd0);
        chk("rstmid/resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid/mdr_out", mdr_out, 32'd0);
        chk("rstmid/ir_out", ir_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ir = 32'd0; exp_mdr = 32'd0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mdr_out !== 32'd0 || req_ready !== 1'b1) bad++;
        end
        chk("rstmid/quiet_after_release", 32'(bad), 32'd0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 300)) * 32'd4;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            w = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 3) == 0);
            do_req("rand", w, f, a, $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1: extra cycles mem_read is held before read data is captured; legal range 0..15.
REQ-002 SHALL provide parameter ADDR_WORDS, default 256: number of 32-bit words in the attached memory.
REQ-003 SHALL provide parameter INST_WORDS, default 32: words 0..INST_WORDS-1 form the instruction region.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_fetch  in  1  instruction fetch; forces a read and ignores req_write.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  request rejected, qualified by resp_valid.
- resp_err_code  out  2  01 misaligned, 10 out of range, 11 write-protect.
- ir_out  out  32  instruction register.
- mdr_out  out  32  memory data register.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  combinational memory read data.

Function
REQ-005 SHALL implement the FSM states IDLE, ACCESS, RESP and ERR.
REQ-006 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-007 On accept, SHALL latch addr, wdata, write (forced to 0 when req_fetch=1) and fetch.
REQ-008 On accept, SHALL evaluate errors in priority order misaligned > out of range > write-protect:
- misaligned: addr[1:0]!=0.
- out of range: word index addr[31:2] >= ADDR_WORDS.
REQ-009 On an error, SHALL go to ERR for 1 cycle with resp_valid=1, resp_err=1 and the code driven, then return to IDLE; no memory strobe is asserted.
REQ-010 On no error, SHALL go to ACCESS, load the wait counter with WAIT_CYCLES and stay in ACCESS for WAIT_CYCLES+1 cycles.
REQ-011 mem_addr and mem_wdata SHALL always reflect the latched values; they hold their last values in IDLE.
REQ-012 Read in ACCESS: mem_read=1 in every ACCESS cycle.
REQ-013 Read capture: on the edge leaving ACCESS, SHALL capture mem_rdata into ir_out if fetch=1, else into mdr_out; the other register is unchanged.
REQ-014 Write in ACCESS: mem_write=1 only in the final ACCESS cycle, giving exactly one write edge; mem_read=0 throughout.
REQ-015 mem_read and mem_write SHALL never both be 1, and both SHALL be 0 outside ACCESS.
REQ-016 RESP SHALL last 1 cycle with resp_valid=1 and resp_err=0, then return to IDLE.
REQ-017 Latency: with acceptance at edge k, resp_valid SHALL be high in the cycle after edge k+WAIT_CYCLES+2, and req_ready SHALL return one cycle later. WAIT_CYCLES=0 gives a 1-cycle ACCESS.
REQ-018 req_valid during ACCESS, RESP or ERR SHALL be ignored; the CPU holds the request until accepted.
REQ-019 resp_err_code SHALL be 00 whenever resp_err=0.

Reset
REQ-020 Asynchronous reset SHALL force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_err_code=00, mem_read=0, mem_write=0, ir_out=0, mdr_out=0, mem_addr=0, mem_wdata=0 and wait counter=0.
REQ-021 Reset asserted mid-ACCESS SHALL drop the strobes immediately, with no capture and no response pulse.

Configuration
REQ-022 With macro MEM_PORT_WPROT_EN defined, a non-fetch write to word index < INST_WORDS SHALL be rejected with code 11 and no mem_write.
REQ-023 Without MEM_PORT_WPROT_EN, code 11 SHALL never be produced and instruction-region writes SHALL proceed normally.

Verification
REQ-024 Fetch at addr 0x0, mem_rdata=0x3C087FFF, WAIT_CYCLES=1 -> mem_read high for 2 cycles, ir_out=0x3C087FFF, resp_valid pulse 3 cycles after accept, mdr_out unchanged.
REQ-025 Store at addr 0x80, wdata 0xDEADBEEF -> mem_write high for exactly 1 cycle with mem_addr=0x80, resp_err=0, mem_read never high.
REQ-026 Load at addr 0x82 -> ERR with code 01; load at addr 0x400 -> code 10; no strobes in either case.
REQ-027 Store at addr 0x10 -> with MEM_PORT_WPROT_EN, code 11 and no mem_write; without it, one mem_write and no error.
REQ-028 Reset asserted in the second ACCESS cycle of a load -> strobes 0 immediately, mdr_out=0, no resp_valid, req_ready=1 after reset release.
REQ-029 Back-to-back requests with req_valid held high -> second request accepted only after RESP, and the first response is unaffected.
